// File: rtl/ram_loader.sv
// Serial boot loader: parses SYNC/ADDR/LEN/DATA/CSUM frames from the UART
// and writes the payload into block RAM while holding the CPU in reset.
module ram_loader #(
  parameter int          ADDR_WIDTH     = 15,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            sum_q, sum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  rx_ready_q;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  accept;
  logic [7:0]            sum_next;

  assign accept   = rx_valid & rx_ready_q;
  assign sum_next = sum_q + rx_data;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    tmo_d      = tmo_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;

    if (accept) begin
      tmo_d = '0;
      sum_d = sum_next;
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_ADDR_H;
            sum_d   = '0;
          end
        end
        // cnt_q temporarily holds the high byte of the address, then of the length
        S_ADDR_H: begin
          cnt_d   = {rx_data, 8'h00};
          state_d = S_ADDR_L;
        end
        S_ADDR_L: begin
          addr_d  = ADDR_WIDTH'({cnt_q[15:8], rx_data});
          state_d = S_LEN_H;
        end
        S_LEN_H: begin
          cnt_d   = {rx_data, 8'h00};
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          cnt_d   = {cnt_q[15:8], rx_data};
          state_d = ({cnt_q[15:8], rx_data} == 16'h0000) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = rx_data;
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_IDLE;
          if (sum_next == 8'h00) begin
            done_d = 1'b1;
          end else begin
            error_d    = 1'b1;
            err_code_d = 2'b01;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d    = S_IDLE;
        tmo_d      = '0;
        error_d    = 1'b1;
        err_code_d = 2'b10;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      rx_ready_q <= 1'b1;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign ram_we    = we_q;
  assign ram_addr  = waddr_q;
  assign ram_wdata = wdata_q;
  assign cpu_hold  = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboarded bench for ram_loader: expected RAM writes and done/error
// events are queued from frame contents and checked by a negedge monitor.
module tb_ram_loader;
  localparam int AW  = 15;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, ram_we, cpu_hold, busy, done, error;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  wr_t wq[$];
  int  eq[$];  // 0 = done, 1 = checksum error, 2 = timeout error
  int  n_pass = 0;
  int  n_total = 0;

  function automatic void chk(string name, bit ok, int act, int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void exp_wr(int a, int d);
    wr_t w;
    w.a = AW'(a);
    w.d = 8'(d);
    wq.push_back(w);
  endfunction

  always @(negedge clk) begin
    wr_t w;
    int  e, got;
    if (ram_we) begin
      if (wq.size() == 0) begin
        chk("write_unexpected", 1'b0, int'(ram_addr), -1);
      end else begin
        w = wq.pop_front();
        chk("write_addr", ram_addr == w.a, int'(ram_addr), int'(w.a));
        chk("write_data", ram_wdata == w.d, int'(ram_wdata), int'(w.d));
      end
    end
    if (done && error) chk("done_error_exclusive", 1'b0, 3, 1);
    if (done || error) begin
      got = done ? 0 : (err_code == 2'b01) ? 1 : (err_code == 2'b10) ? 2 : 3;
      if (eq.size() == 0) begin
        chk("event_unexpected", 1'b0, got, -1);
      end else begin
        e = eq.pop_front();
        chk("event", got == e, got, e);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_q(input logic [7:0] bs[$]);
    foreach (bs[i]) send(bs[i]);
  endtask

  task automatic rand_frame(input int addr, input int len, input bit bad, input int maxgap);
    logic [7:0] sum;
    logic [7:0] hdr[4];
    logic [7:0] d;
    sum = 8'h00;
    hdr[0] = 8'(addr >> 8); hdr[1] = 8'(addr);
    hdr[2] = 8'(len >> 8);  hdr[3] = 8'(len);
    idle($urandom_range(0, maxgap));
    send(8'hA5);
    for (int i = 0; i < 4; i++) begin
      sum += hdr[i];
      idle($urandom_range(0, maxgap));
      send(hdr[i]);
    end
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      sum += d;
      exp_wr((addr + i) % (1 << AW), d);
      idle($urandom_range(0, maxgap));
      send(d);
    end
    eq.push_back(bad ? 1 : 0);
    idle($urandom_range(0, maxgap));
    send(bad ? 8'(8'h00 - sum + 8'h01) : 8'(8'h00 - sum));
  endtask

  logic [7:0] bq[$];

  initial begin
    idle(3);
    chk("reset_outputs", {rx_ready, ram_we, ram_addr, ram_wdata, cpu_hold, busy,
        done, error, err_code} == '0, int'(ram_addr), 0);
    rst = 1'b0;
    idle(1);
    chk("rx_ready_after_reset", rx_ready == 1'b1, int'(rx_ready), 1);

    bq = '{8'h00, 8'hFF, 8'h12};
    send_q(bq);
    chk("noise_idle_busy", busy == 1'b0, int'(busy), 0);

    exp_wr('h0200, 'h11); exp_wr('h0201, 'h22); exp_wr('h0202, 'h33);
    eq.push_back(0);
    chk("hold_before_sync", cpu_hold == 1'b0, int'(cpu_hold), 0);
    send(8'hA5);
    chk("hold_after_sync", cpu_hold == 1'b1, int'(cpu_hold), 1);
    chk("busy_after_sync", busy == 1'b1, int'(busy), 1);
    bq = '{8'h02, 8'h00, 8'h00, 8'h03};
    send_q(bq);
    send(8'h11);
    chk("basic_we0", {ram_we, ram_addr, ram_wdata} == {1'b1, 15'h0200, 8'h11}, int'(ram_addr), 'h0200);
    send(8'h22);
    chk("basic_we1", {ram_we, ram_addr, ram_wdata} == {1'b1, 15'h0201, 8'h22}, int'(ram_addr), 'h0201);
    send(8'h33);
    chk("basic_we2", {ram_we, ram_addr, ram_wdata} == {1'b1, 15'h0202, 8'h33}, int'(ram_addr), 'h0202);
    send(8'h95);
    chk("basic_done", done == 1'b1, int'(done), 1);
    chk("basic_we_off", ram_we == 1'b0, int'(ram_we), 0);
    chk("basic_hold_fall", {cpu_hold, busy} == 2'b00, int'({cpu_hold, busy}), 0);

    eq.push_back(0);
    bq = '{8'hA5, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h82};
    send_q(bq);
    chk("zero_len_done", done == 1'b1, int'(done), 1);
    exp_wr('h7FFF, 'hAA); exp_wr('h0000, 'hBB);
    eq.push_back(0);
    bq = '{8'hA5, 8'h7F, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h1B};
    send_q(bq);

    exp_wr('h0200, 'h5A);
    eq.push_back(1);
    bq = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'h5A, 8'h00};
    send_q(bq);
    chk("bad_csum_error", {done, error, err_code} == 4'b0101, int'({done, error, err_code}), 'h5);
    idle(3);
    chk("err_code_holds", err_code == 2'b01, int'(err_code), 1);

    eq.push_back(2);
    bq = '{8'hA5, 8'h02, 8'h00};
    send_q(bq);
    idle(TMO - 1);
    chk("timeout_not_early", {busy, error} == 2'b10, int'({busy, error}), 2);
    idle(1);
    chk("timeout_fire", {error, err_code} == 3'b110, int'({error, err_code}), 6);
    chk("timeout_hold_fall", {cpu_hold, busy} == 2'b00, int'({cpu_hold, busy}), 0);

    eq.push_back(0);
    bq = '{8'hA5, 8'h02, 8'h00};
    send_q(bq);
    idle(TMO - 1);
    send(8'h00);
    chk("timeout_byte_wins", {busy, error} == 2'b10, int'({busy, error}), 2);
    idle(TMO - 1);
    send(8'h00);
    send(8'hFE);
    chk("late_frame_done", done == 1'b1, int'(done), 1);

    exp_wr('h0100, 'hC1); exp_wr('h0101, 'hC2);
    bq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'hC1, 8'hC2};
    send_q(bq);
    rst = 1'b1;
    idle(1);
    chk("midframe_reset_outputs", {rx_ready, ram_we, ram_addr, ram_wdata, cpu_hold, busy,
        done, error, err_code} == '0, int'({ram_we, busy}), 0);
    rst = 1'b0;
    idle(1);
    send(8'hC3);
    chk("after_reset_idle", busy == 1'b0, int'(busy), 0);
    rand_frame('h0300, 4, 1'b0, 0);

    rand_frame('h7F00, 300, 1'b0, 20);
    for (int k = 0; k < 4; k++)
      rand_frame(int'($urandom_range(0, 'hFFFF)), int'($urandom_range(1, 20)),
                 1'($urandom_range(0, 1)), 3);

    idle(5);
    chk("writes_drained", wq.size() == 0, wq.size(), 0);
    chk("events_drained", eq.size() == 0, eq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ram_loader.md
# ram_loader

Serial boot loader that sits directly upstream of the 32 KB block RAM. It parses framed byte streams from the UART receiver and drives the RAM's single write port with one write per data byte. While a frame is in progress it holds the 6502 in reset, so that a program can be downloaded into RAM and then executed.

## Interface

Parameters:
- ADDR_WIDTH, 15, RAM address width; frame addresses are truncated to this width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 5_000_000, idle cycles allowed mid-frame before abort; must be ≥ 2.

Ports:
- clk  in  1  system clock; the block has one clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid & rx_ready at a rising clk edge.
- ram_we  out  1  RAM write enable, one-cycle pulse per data byte.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  8  RAM write data.
- cpu_hold  out  1  high while a frame is in progress; ORed into the CPU reset.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a frame completes with a good checksum.
- error  out  1  one-cycle pulse when a frame is aborted or fails its checksum.
- err_code  out  2  cause of the last error: 01 checksum, 10 timeout; holds its value until the next error or reset.

## Operation

- Frame format: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA×LEN, CSUM.
- Checksum rule: the 8-bit sum, modulo 256, of every byte after SYNC, including CSUM, must equal 0x00.
- State machine: IDLE → ADDR_H → ADDR_L → LEN_H → LEN_L → DATA → CSUM → IDLE.
  - Each transition occurs on an accepted byte.
  - In LEN_L, a length of 0 goes directly to CSUM.
  - In DATA, the block moves to CSUM after the LEN-th data byte is accepted.
- IDLE: bytes other than SYNC_BYTE are accepted and discarded.
- Address: {ADDR_H, ADDR_L}[ADDR_WIDTH-1:0]. The address increments after each data byte and wraps modulo 2^ADDR_WIDTH (0x7FFF → 0x0000 at default width).
- Length: 16-bit unsigned count, 0 to 65535. A length above 2^ADDR_WIDTH wraps the address and overwrites earlier bytes. This is legal.
- Writes are issued as data arrives. A checksum failure does not undo them; it only raises error with err_code=01 and leaves done low.
- Timeout:
  - In any non-IDLE state, a counter runs and is cleared on every accepted byte.
  - When TIMEOUT_CYCLES consecutive cycles pass with no accepted byte, the state returns to IDLE and error pulses with err_code=10.
  - If a byte is accepted on the same edge the timeout would fire, the byte wins and the counter clears.
- A SYNC_BYTE value received in a non-IDLE state is ordinary frame data; it does not restart the frame.
- Reset mid-frame: the state returns to IDLE immediately. No further RAM writes occur, and neither done nor error pulses.

## Timing

- All outputs are registered.
- Reset values: rx_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=0, busy=0, done=0, error=0, err_code=00.
- rx_ready goes to 1 on the first edge after rst deasserts and stays 1. The loader accepts one byte every cycle with no back-pressure.
- Data byte accepted at edge N:
  - ram_we=1 with matching ram_addr/ram_wdata during cycle N+1 (visible after edge N).
  - ram_we returns to 0 at edge N+1 unless another data byte is accepted at that edge.
  - Back-to-back data bytes give back-to-back writes to consecutive addresses.
- cpu_hold and busy rise in the cycle after SYNC is accepted. They fall in the cycle after CSUM is accepted or the timeout fires, coincident with the done/error pulse.
- done and error are mutually exclusive and each lasts exactly one cycle.
- Latency from CSUM acceptance to done/error: 1 cycle.

## Test plan

- Basic frame: A5 02 00 00 03 11 22 33 95 at one byte per cycle → writes 0x0200=11, 0x0201=22, 0x0202=33 on 3 consecutive cycles; done pulses once; error stays 0; cpu_hold spans SYNC+1 through CSUM+1.
- Zero length and address wrap:
  - A5 7F FF 00 00 82 → no ram_we; done pulses.
  - Then A5 7F FF 00 02 AA BB 1B → writes 0x7FFF=AA and 0x0000=BB; done pulses.
- Bad checksum: A5 02 00 00 01 5A 00 → write 0x0200=5A occurs; error pulses with err_code=01; done stays 0.
- Timeout with TIMEOUT_CYCLES=100: A5 02 00 then silence → after exactly 100 idle cycles, error pulses with err_code=10 and cpu_hold and busy fall. A byte arriving at cycle 100 instead keeps the frame alive.
- Noise and reset:
  - Bytes 00 FF 12 in IDLE → ignored.
  - rst asserted after the second data byte of a 3-byte frame → no further writes; all outputs return to their reset values.
  - A following valid frame loads correctly.
- Random gaps between bytes, each shorter than the timeout, over a 300-byte frame at 0x7F00 → every byte lands at the correct wrapped address; done pulses.
